// File: rtl/jtframe_rom_arb.sv
// N-slot SDRAM ROM arbiter: per-slot one-word tagged cache, one SDRAM read in flight,
// round-robin grant with an optional vblank priority mask.
module jtframe_rom_arb #(
    parameter int unsigned           NSLOT   = 4,
    parameter int unsigned           SLOT_AW = 22,
    parameter logic [2*NSLOT-1:0]    DWSEL   = '0,
    parameter logic [22*NSLOT-1:0]   OFFSET  = '0,
    parameter logic [NSLOT-1:0]      VB_PRI  = '0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_vblank,
    input  logic                  i_downloading,
    input  logic                  i_loop_rst,
    input  logic [NSLOT-1:0]      i_slot_cs,
    input  logic [22*NSLOT-1:0]   i_slot_addr,
    output logic [NSLOT-1:0]      o_slot_ok,
    output logic [32*NSLOT-1:0]   o_slot_dout,
    output logic                  o_sdram_req,
    output logic [21:0]           o_sdram_addr,
    input  logic                  i_sdram_ack,
    input  logic                  i_data_rdy,
    input  logic [31:0]           i_data_read,
    output logic                  o_refresh_en
);

    localparam int unsigned PW = (NSLOT > 1) ? $clog2(NSLOT) : 1;
    localparam logic [21:0] AW_MASK =
        (SLOT_AW >= 22) ? 22'h3F_FFFF : 22'((64'd1 << SLOT_AW) - 64'd1);

    typedef enum logic [1:0] {StIdle, StWaitAck, StWaitData} state_t;

    state_t                   r_state, w_state_d;
    logic                     r_sdram_req, w_sdram_req_d;
    logic [21:0]              r_sdram_addr, w_sdram_addr_d;
    logic [PW-1:0]            r_winner, w_winner_d;
    logic [21:0]              r_ctag, w_ctag_d;
    logic [PW-1:0]            r_rr_ptr, w_rr_ptr_d;
    logic                     r_discard, w_discard_d;
    logic [NSLOT-1:0]         r_valid, w_valid_d;
    logic [NSLOT-1:0][21:0]   r_tag, w_tag_d;
    logic [NSLOT-1:0][31:0]   r_data;
    logic [NSLOT-1:0]         r_slot_ok;

    logic [NSLOT-1:0][21:0]   w_tag;
    logic [NSLOT-1:0][21:0]   w_word;
    logic [NSLOT-1:0]         w_hit;
    logic [NSLOT-1:0]         w_match_d;
    logic [NSLOT-1:0]         w_pending;
    logic                     w_inval;
    logic                     w_store;
    logic                     w_win;
    logic [PW-1:0]            w_win_idx;

    assign w_inval = i_downloading | i_loop_rst;

    // Per-slot address decode, tag compare and output lane select
    for (genvar g = 0; g < NSLOT; g++) begin : g_slot
        localparam logic [1:0]  DW  = DWSEL[2*g +: 2];
        localparam logic [21:0] OFF = OFFSET[22*g +: 22];

        logic [21:0] w_a;
        logic [21:0] w_t;
        logic [21:0] w_wd;
        logic [31:0] w_shift;
        logic [31:0] w_sel;

        assign w_a     = i_slot_addr[22*g +: 22] & AW_MASK;
        assign w_shift = r_data[g] >> {w_a[1:0], 3'b000};

        always_comb begin
            w_t   = '0;
            w_wd  = '0;
            w_sel = '0;
            case (DW)
                2'd0: begin
                    w_t   = {2'b00, w_a[21:2]};
                    w_wd  = OFF + {1'b0, w_a[21:1]};
                    w_sel = {24'd0, w_shift[7:0]};
                end
                2'd1: begin
                    w_t   = {1'b0, w_a[21:1]};
                    w_wd  = OFF + w_a;
                    w_sel = w_a[0] ? {16'd0, r_data[g][31:16]} : {16'd0, r_data[g][15:0]};
                end
                default: begin
                    w_t   = w_a;
                    w_wd  = OFF + {w_a[20:0], 1'b0};
                    w_sel = r_data[g];
                end
            endcase
        end

        assign w_tag[g]                = w_t;
        assign w_word[g]               = {w_wd[21:1], 1'b0};
        assign w_hit[g]                = r_valid[g] & (r_tag[g] == w_t);
        assign o_slot_dout[32*g +: 32] = w_sel;
    end

    // Reset is folded in so refresh stays enabled while rst is held
    assign w_pending = i_slot_cs & ~w_hit & {NSLOT{~(w_inval | i_rst)}};

    always_comb begin
        w_win     = 1'b0;
        w_win_idx = '0;
        if (i_vblank && |(w_pending & VB_PRI)) begin
            w_win = 1'b1;
            for (int k = int'(NSLOT) - 1; k >= 0; k--) begin
                if (w_pending[k] && VB_PRI[k]) begin
                    w_win_idx = PW'(k);
                end
            end
        end else begin
            for (int k = 0; k < int'(NSLOT); k++) begin
                int idx;
                idx = (int'(r_rr_ptr) + k) % int'(NSLOT);
                if (!w_win && w_pending[idx]) begin
                    w_win     = 1'b1;
                    w_win_idx = PW'(idx);
                end
            end
        end
    end

    always_comb begin
        w_state_d      = r_state;
        w_sdram_req_d  = r_sdram_req;
        w_sdram_addr_d = r_sdram_addr;
        w_winner_d     = r_winner;
        w_ctag_d       = r_ctag;
        w_rr_ptr_d     = r_rr_ptr;
        w_discard_d    = r_discard | w_inval;
        w_store        = 1'b0;
        case (r_state)
            StIdle: begin
                w_discard_d = 1'b0;
                if (w_win) begin
                    w_state_d      = StWaitAck;
                    w_sdram_req_d  = 1'b1;
                    w_sdram_addr_d = w_word[w_win_idx];
                    w_winner_d     = w_win_idx;
                    w_ctag_d       = w_tag[w_win_idx];
                end
            end
            StWaitAck: begin
                // A data_rdy coinciding with ack is ignored here
                if (i_sdram_ack) begin
                    w_state_d     = StWaitData;
                    w_sdram_req_d = 1'b0;
                end
            end
            StWaitData: begin
                if (i_data_rdy) begin
                    w_state_d  = StIdle;
                    w_store    = ~w_inval & ~r_discard;
                    w_rr_ptr_d = (r_winner == PW'(NSLOT - 1)) ? '0 : r_winner + 1'b1;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // Next cache state drives the registered ok so it tracks fills and invalidations
    always_comb begin
        w_valid_d = w_inval ? '0 : r_valid;
        w_tag_d   = r_tag;
        for (int i = 0; i < int'(NSLOT); i++) begin
            if (w_store && r_winner == PW'(i)) begin
                w_valid_d[i] = 1'b1;
                w_tag_d[i]   = r_ctag;
            end
            w_match_d[i] = (w_tag_d[i] == w_tag[i]);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= StIdle;
            r_sdram_req  <= 1'b0;
            r_sdram_addr <= '0;
            r_winner     <= '0;
            r_ctag       <= '0;
            r_rr_ptr     <= '0;
            r_discard    <= 1'b0;
            r_valid      <= '0;
            r_tag        <= '0;
            r_data       <= '0;
            r_slot_ok    <= '0;
        end else begin
            r_state      <= w_state_d;
            r_sdram_req  <= w_sdram_req_d;
            r_sdram_addr <= w_sdram_addr_d;
            r_winner     <= w_winner_d;
            r_ctag       <= w_ctag_d;
            r_rr_ptr     <= w_rr_ptr_d;
            r_discard    <= w_discard_d;
            r_valid      <= w_valid_d;
            r_tag        <= w_tag_d;
            if (w_store) begin
                r_data[r_winner] <= i_data_read;
            end
            r_slot_ok    <= i_slot_cs & w_valid_d & w_match_d;
        end
    end

    assign o_slot_ok    = r_slot_ok;
    assign o_sdram_req  = r_sdram_req;
    assign o_sdram_addr = r_sdram_addr;
    assign o_refresh_en = (r_state == StIdle) && (w_pending == '0);

endmodule

// File: tb/tb_jtframe_rom_arb.sv
// Bench for jtframe_rom_arb: slots 0,1,3 are 8-bit at offset 0, slot 2 is 32-bit at 0x20000,
// slot 3 has vblank priority. Expected SDRAM transactions are queued and matched in order.
module tb_jtframe_rom_arb;

    localparam int unsigned NSLOT = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               vblank = 1'b0;
    logic               downloading = 1'b0;
    logic               loop_rst = 1'b0;
    logic [NSLOT-1:0]   slot_cs = '0;
    logic [21:0]        addr_v [NSLOT];
    logic [22*NSLOT-1:0] slot_addr;
    logic [NSLOT-1:0]   slot_ok;
    logic [32*NSLOT-1:0] slot_dout;
    logic               sdram_req;
    logic [21:0]        sdram_addr;
    logic               sdram_ack = 1'b0;
    logic               data_rdy = 1'b0;
    logic [31:0]        data_read = '0;
    logic               refresh_en;

    typedef struct {
        logic [21:0] addr;
        logic [31:0] data;
    } txn_t;

    txn_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    assign slot_addr = {addr_v[3], addr_v[2], addr_v[1], addr_v[0]};

    always #5 clk = ~clk;

    jtframe_rom_arb #(
        .NSLOT   (NSLOT),
        .SLOT_AW (22),
        .DWSEL   (8'h20),
        .OFFSET  ({22'd0, 22'h20000, 22'd0, 22'd0}),
        .VB_PRI  (4'b1000)
    ) u_dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_vblank      (vblank),
        .i_downloading (downloading),
        .i_loop_rst    (loop_rst),
        .i_slot_cs     (slot_cs),
        .i_slot_addr   (slot_addr),
        .o_slot_ok     (slot_ok),
        .o_slot_dout   (slot_dout),
        .o_sdram_req   (sdram_req),
        .o_sdram_addr  (sdram_addr),
        .i_sdram_ack   (sdram_ack),
        .i_data_rdy    (data_rdy),
        .i_data_read   (data_read),
        .o_refresh_en  (refresh_en)
    );

    function automatic logic [31:0] exp_dout(int s, logic [21:0] a, logic [31:0] d);
        logic [31:0] sh;
        if (s == 2) return d;
        sh = d >> {a[1:0], 3'b000};
        return {24'd0, sh[7:0]};
    endfunction

    function automatic logic [21:0] exp_word(int s, logic [21:0] a);
        if (s == 2) return 22'h20000 + {a[20:0], 1'b0};
        return {1'b0, a[21:1]} & 22'h3F_FFFE;
    endfunction

    function automatic logic [31:0] pattern(logic [21:0] a);
        return {10'h2A5, a};
    endfunction

    // Controller side of one read: wait for req, ack after two cycles, return data
    task automatic serve(input logic [31:0] d, output logic [21:0] seen, output bit timeout);
        int n = 0;
        timeout = 1'b0;
        seen = 'x;
        while (!sdram_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!sdram_req) begin
            timeout = 1'b1;
            return;
        end
        seen = sdram_addr;
        repeat (2) @(negedge clk);
        sdram_ack = 1'b1;
        @(negedge clk);
        sdram_ack = 1'b0;
        @(negedge clk);
        data_read = d;
        data_rdy  = 1'b1;
        @(negedge clk);
        data_rdy  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < NSLOT; i++) addr_v[i] = '0;
        slot_cs = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++;
        if (slot_ok !== '0 || sdram_req !== 1'b0 || sdram_addr !== '0 || refresh_en !== 1'b1) begin
            n_err++;
            $display("FAIL reset_outputs: ok=%b req=%b addr=%h refresh=%b, want 0 0 0 1",
                     slot_ok, sdram_req, sdram_addr, refresh_en);
        end
        n_vec++;
        if (slot_dout !== '0) begin
            n_err++;
            $display("FAIL reset_dout: got %h want 0", slot_dout);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_miss();
        logic [21:0] seen;
        bit          to;
        addr_v[0] = 22'h005;
        slot_cs   = 4'b0001;
        @(negedge clk);
        n_vec++;
        if (sdram_req !== 1'b1 || sdram_addr !== 22'h002) begin
            n_err++;
            $display("FAIL miss_latency: req=%b addr=%h, want 1 002", sdram_req, sdram_addr);
        end
        n_vec++;
        if (refresh_en !== 1'b0) begin
            n_err++;
            $display("FAIL refresh_busy: got %b want 0", refresh_en);
        end
        sb.push_back('{addr: 22'h002, data: 32'hDDCC_BBAA});
        while (sb.size() > 0) begin
            txn_t t = sb.pop_front();
            serve(t.data, seen, to);
            n_vec++;
            if (to || seen !== t.addr) begin
                n_err++;
                $display("FAIL single_addr: got %h timeout=%0d want %h", seen, to, t.addr);
            end
        end
        n_vec++;
        if (slot_ok[0] !== 1'b1 || slot_dout[31:0] !== 32'h0000_00BB) begin
            n_err++;
            $display("FAIL single_data: ok=%b dout=%h want 1 000000bb", slot_ok[0], slot_dout[31:0]);
        end
        n_vec++;
        if (refresh_en !== 1'b1) begin
            n_err++;
            $display("FAIL refresh_idle: got %b want 1", refresh_en);
        end
    endtask

    task automatic test_same_tag();
        logic [21:0] seen;
        bit          to;
        addr_v[0] = 22'h006;
        @(negedge clk);
        n_vec++;
        if (slot_ok[0] !== 1'b1 || slot_dout[31:0] !== 32'h0000_00CC || sdram_req !== 1'b0) begin
            n_err++;
            $display("FAIL same_tag: ok=%b dout=%h req=%b want 1 000000cc 0",
                     slot_ok[0], slot_dout[31:0], sdram_req);
        end
        addr_v[0] = 22'h008;
        @(negedge clk);
        n_vec++;
        if (slot_ok[0] !== 1'b0 || sdram_req !== 1'b1) begin
            n_err++;
            $display("FAIL new_tag: ok=%b req=%b want 0 1", slot_ok[0], sdram_req);
        end
        sb.push_back('{addr: 22'h004, data: 32'h4433_2211});
        while (sb.size() > 0) begin
            txn_t t = sb.pop_front();
            serve(t.data, seen, to);
            n_vec++;
            if (to || seen !== t.addr) begin
                n_err++;
                $display("FAIL new_tag_addr: got %h timeout=%0d want %h", seen, to, t.addr);
            end
        end
        n_vec++;
        if (slot_ok[0] !== 1'b1 || slot_dout[31:0] !== 32'h0000_0011) begin
            n_err++;
            $display("FAIL new_tag_data: ok=%b dout=%h want 1 00000011", slot_ok[0], slot_dout[31:0]);
        end
    endtask

    // Present new addresses on the masked slots together and queue expected reads in 'order'
    task automatic run_round(input string name, input logic [NSLOT-1:0] mask,
                             input logic [21:0] na [NSLOT], input int order [$]);
        logic [21:0] seen;
        bit          to;
        for (int i = 0; i < NSLOT; i++) if (mask[i]) addr_v[i] = na[i];
        foreach (order[j]) begin
            sb.push_back('{addr: exp_word(order[j], na[order[j]]),
                           data: pattern(na[order[j]])});
        end
        while (sb.size() > 0) begin
            txn_t t = sb.pop_front();
            serve(t.data, seen, to);
            n_vec++;
            if (to || seen !== t.addr) begin
                n_err++;
                $display("FAIL %s_order: got %h timeout=%0d want %h", name, seen, to, t.addr);
            end
        end
        @(negedge clk);
        for (int i = 0; i < NSLOT; i++) begin
            if (mask[i]) begin
                n_vec++;
                if (slot_ok[i] !== 1'b1 ||
                    slot_dout[32*i +: 32] !== exp_dout(i, na[i], pattern(na[i]))) begin
                    n_err++;
                    $display("FAIL %s_data%0d: ok=%b dout=%h want 1 %h", name, i, slot_ok[i],
                             slot_dout[32*i +: 32], exp_dout(i, na[i], pattern(na[i])));
                end
            end
        end
    endtask

    task automatic test_round_robin();
        logic [21:0] na [NSLOT];
        do_reset();
        slot_cs = 4'b1111;
        na = '{22'h100, 22'h200, 22'h040, 22'h300};
        run_round("rr0", 4'b1111, na, '{0, 1, 2, 3});
        na = '{22'h100, 22'h208, 22'h040, 22'h300};
        run_round("rr_one", 4'b0010, na, '{1});
        na = '{22'h104, 22'h204, 22'h044, 22'h304};
        run_round("rr2", 4'b1111, na, '{2, 3, 0, 1});
    endtask

    task automatic test_vblank_pri();
        logic [21:0] na [NSLOT];
        na = '{22'h108, 22'h204, 22'h044, 22'h304};
        run_round("vb_pre", 4'b0001, na, '{0});
        vblank = 1'b1;
        na = '{22'h108, 22'h20C, 22'h044, 22'h308};
        run_round("vb_on", 4'b1010, na, '{3, 1});
        vblank = 1'b0;
        na = '{22'h10C, 22'h20C, 22'h044, 22'h308};
        run_round("vb_pre2", 4'b0001, na, '{0});
        na = '{22'h10C, 22'h210, 22'h044, 22'h30C};
        run_round("vb_off", 4'b1010, na, '{1, 3});
    endtask

    task automatic test_download();
        logic [21:0] seen;
        bit          to;
        int          n = 0;
        slot_cs   = 4'b0100;
        addr_v[2] = 22'h010;
        while (!sdram_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        n_vec++;
        if (sdram_req !== 1'b1 || sdram_addr !== 22'h20020) begin
            n_err++;
            $display("FAIL dl_addr: req=%b addr=%h want 1 20020", sdram_req, sdram_addr);
        end
        @(negedge clk);
        sdram_ack = 1'b1;
        @(negedge clk);
        sdram_ack   = 1'b0;
        downloading = 1'b1;
        @(negedge clk);
        downloading = 1'b0;
        data_read   = 32'h1234_5678;
        data_rdy    = 1'b1;
        @(negedge clk);
        data_rdy = 1'b0;
        n_vec++;
        if (slot_ok[2] !== 1'b0) begin
            n_err++;
            $display("FAIL dl_discard: ok=%b want 0", slot_ok[2]);
        end
        sb.push_back('{addr: 22'h20020, data: 32'hCAFE_F00D});
        while (sb.size() > 0) begin
            txn_t t = sb.pop_front();
            serve(t.data, seen, to);
            n_vec++;
            if (to || seen !== t.addr) begin
                n_err++;
                $display("FAIL dl_rereq: got %h timeout=%0d want %h", seen, to, t.addr);
            end
        end
        n_vec++;
        if (slot_ok[2] !== 1'b1 || slot_dout[95:64] !== 32'hCAFE_F00D) begin
            n_err++;
            $display("FAIL dl_refill: ok=%b dout=%h want 1 cafef00d", slot_ok[2], slot_dout[95:64]);
        end
    endtask

    task automatic test_rst_mid();
        int n = 0;
        addr_v[2] = 22'h014;
        while (!sdram_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        n_vec++;
        if (sdram_req !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid_req: got %b want 1", sdram_req);
        end
        rst = 1'b1;
        @(negedge clk);
        n_vec++;
        if (sdram_req !== 1'b0 || slot_ok !== '0 || refresh_en !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid: req=%b ok=%b refresh=%b want 0 0000 1",
                     sdram_req, slot_ok, refresh_en);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_miss();
        test_same_tag();
        test_round_robin();
        test_vblank_pri();
        test_download();
        test_rst_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
